// File: rtl/dcache_store_port_pkg.sv
// rtl/dcache_store_port_pkg.sv - shared geometry, size codes and FSM states for the store port
package dcache_store_port_pkg;

    localparam int DCACHE_WORD_SIZE        = 32;
    localparam int DCACHE_ADDRESS_WIDTH    = 32;
    localparam int DCACHE_SIZE_WRITE_WIDTH = 2;
    localparam int DCACHE_LINES            = 4;
    localparam int DCACHE_LINE_BYTES       = 16;
    localparam int DCACHE_LINE_DATA_WIDTH  = DCACHE_LINE_BYTES * 8;

    // Store size codes; anything other than BYTE_SIZE is handled as a full word.
    localparam logic [DCACHE_SIZE_WRITE_WIDTH-1:0] BYTE_SIZE      = 2'd0;
    localparam logic [DCACHE_SIZE_WRITE_WIDTH-1:0] FULL_WORD_SIZE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WB   = 2'd2,
        ST_FILL = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_store_port_if.sv
// rtl/dcache_store_port_if.sv - store-buffer drain and line-wide memory bus seen by the store port
interface dcache_store_port_if
    import dcache_store_port_pkg::*;
#(
    parameter int WIDTH            = DCACHE_ADDRESS_WIDTH,
    parameter int WORD_SIZE        = DCACHE_WORD_SIZE,
    parameter int SIZE_WRITE_WIDTH = DCACHE_SIZE_WRITE_WIDTH,
    parameter int LINE_BYTES       = DCACHE_LINE_BYTES
);

    logic                        cache_wenable;
    logic [WIDTH-1:0]            cache_physical_address;
    logic [WORD_SIZE-1:0]        cache_store_value;
    logic [SIZE_WRITE_WIDTH-1:0] cache_store_size;
    logic                        store_success;
    logic                        busy;

    logic                        mem_req;
    logic                        mem_we;
    logic [WIDTH-1:0]            mem_addr;
    logic [LINE_BYTES*8-1:0]     mem_wdata;
    logic                        mem_ready;
    logic                        mem_rvalid;
    logic [LINE_BYTES*8-1:0]     mem_rdata;

    // Environment side: store buffer plus backing memory.
    modport master (
        output cache_wenable, cache_physical_address, cache_store_value, cache_store_size,
        output mem_ready, mem_rvalid, mem_rdata,
        input  store_success, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Cache side.
    modport slave (
        input  cache_wenable, cache_physical_address, cache_store_value, cache_store_size,
        input  mem_ready, mem_rvalid, mem_rdata,
        output store_success, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - direct-mapped valid/dirty/tag/data storage with merge and install ports
module dcache_line_array
    import dcache_store_port_pkg::*;
#(
    parameter int LINES      = DCACHE_LINES,
    parameter int LINE_BYTES = DCACHE_LINE_BYTES,
    parameter int TAG_W      = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(LINES)-1:0]      index,
    input  logic [TAG_W-1:0]              tag,
    output logic                          hit,
    output logic                          victim_valid,
    output logic                          victim_dirty,
    output logic [TAG_W-1:0]              victim_tag,
    output logic [LINE_BYTES*8-1:0]       victim_data,
    input  logic                          merge_en,
    input  logic [LINE_BYTES-1:0]         merge_be,
    input  logic [LINE_BYTES*8-1:0]       merge_data,
    input  logic                          clean_en,
    input  logic                          install_en,
    input  logic [LINE_BYTES*8-1:0]       install_data
);

    logic [LINES-1:0]          valid_q;
    logic [LINES-1:0]          dirty_q;
    logic [TAG_W-1:0]          tag_q  [LINES];
    logic [LINE_BYTES*8-1:0]   data_q [LINES];

    // Lookup is purely combinational so the FSM can decide hit/miss in the request cycle.
    assign victim_valid = valid_q[index];
    assign victim_dirty = dirty_q[index];
    assign victim_tag   = tag_q[index];
    assign victim_data  = data_q[index];
    assign hit          = valid_q[index] && (tag_q[index] == tag);

    // Storage update: reset wipes everything, so a reset mid-fill never installs a line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (install_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            tag_q[index]   <= tag;
            data_q[index]  <= install_data;
        end else if (merge_en) begin
            dirty_q[index] <= 1'b1;
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (merge_be[b]) begin
                    data_q[index][8*b +: 8] <= merge_data[8*b +: 8];
                end
            end
        end else if (clean_en) begin
            dirty_q[index] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_store_port.sv
// rtl/dcache_store_port.sv - write-back write-allocate store responder for the store buffer drain
module dcache_store_port
    import dcache_store_port_pkg::*;
#(
    parameter int LINES            = DCACHE_LINES,
    parameter int LINE_BYTES       = DCACHE_LINE_BYTES,
    parameter int WORD_SIZE        = DCACHE_WORD_SIZE,
    parameter int WIDTH            = DCACHE_ADDRESS_WIDTH,
    parameter int SIZE_WRITE_WIDTH = DCACHE_SIZE_WRITE_WIDTH
) (
    input logic                clk,
    input logic                rst,
    dcache_store_port_if.slave bus
);

    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(LINES);
    localparam int TAG_W      = WIDTH - OFF_W - IDX_W;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORD_BYTES = WORD_SIZE / 8;
    localparam int WB_W       = $clog2(WORD_BYTES);
    localparam int WORDS      = LINE_BYTES / WORD_BYTES;

    state_t state;

    logic               success_q;
    logic               busy_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [WIDTH-1:0]   mem_addr_q;
    logic [LINE_W-1:0]  mem_wdata_q;

    logic [IDX_W-1:0]   req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [OFF_W-1:0]   req_offset;
    logic [OFF_W-1:0]   word_base;
    logic               is_byte;
    logic [WIDTH-1:0]   fill_addr;
    logic [WIDTH-1:0]   victim_addr;

    logic               hit;
    logic               victim_valid;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic [LINE_W-1:0]  victim_data;

    logic               merge_en;
    logic               clean_en;
    logic               install_en;
    logic [LINE_BYTES-1:0] merge_be;
    logic [LINE_W-1:0]  merge_data;

    assign req_offset  = bus.cache_physical_address[OFF_W-1:0];
    assign req_index   = bus.cache_physical_address[OFF_W +: IDX_W];
    assign req_tag     = bus.cache_physical_address[WIDTH-1 -: TAG_W];
    // Word stores are aligned: the low address bits inside the word are dropped.
    assign word_base   = {req_offset[OFF_W-1:WB_W], {WB_W{1'b0}}};
    assign is_byte     = (bus.cache_store_size == SIZE_WRITE_WIDTH'(BYTE_SIZE));
    assign fill_addr   = {req_tag, req_index, {OFF_W{1'b0}}};
    assign victim_addr = {victim_tag, req_index, {OFF_W{1'b0}}};

    // Array side effects follow the current state; all are exclusive by construction.
    assign merge_en   = (state == ST_IDLE) && bus.cache_wenable && hit;
    assign clean_en   = (state == ST_WB)   && bus.mem_ready;
    assign install_en = (state == ST_FILL) && bus.mem_rvalid;

    // Store data is replicated across the line and steered by byte enables.
    always_comb begin
        merge_be   = '0;
        merge_data = '0;
        if (is_byte) begin
            merge_be   = LINE_BYTES'(1) << req_offset;
            merge_data = {LINE_BYTES{bus.cache_store_value[7:0]}};
        end else begin
            merge_be   = LINE_BYTES'({WORD_BYTES{1'b1}}) << word_base;
            merge_data = {WORDS{bus.cache_store_value}};
        end
    end

    dcache_line_array #(
        .LINES      (LINES),
        .LINE_BYTES (LINE_BYTES),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk          (clk),
        .rst          (rst),
        .index        (req_index),
        .tag          (req_tag),
        .hit          (hit),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .merge_en     (merge_en),
        .merge_be     (merge_be),
        .merge_data   (merge_data),
        .clean_en     (clean_en),
        .install_en   (install_en),
        .install_data (bus.mem_rdata)
    );

    // Control FSM with registered outputs; memory address/data are captured on entry and held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            success_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cache_wenable) begin
                        busy_q <= 1'b1;
                        if (hit) begin
                            state     <= ST_RESP;
                            success_q <= 1'b1;
                        end else if (victim_valid && victim_dirty) begin
                            state       <= ST_WB;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= victim_addr;
                            mem_wdata_q <= victim_data;
                        end else begin
                            state      <= ST_FILL;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= fill_addr;
                        end
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    success_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                ST_WB: begin
                    if (bus.mem_ready) begin
                        state      <= ST_FILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= fill_addr;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_rvalid) begin
                        state     <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.store_success = success_q;
    assign bus.busy          = busy_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_dcache_store_port.sv
// tb/tb_dcache_store_port.sv - self-checking bench for dcache_store_port against a memory-level model
module tb_dcache_store_port;
    import dcache_store_port_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dcache_store_port_if bus ();

    dcache_store_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural byte memory (every store applied) and the backing memory behind the cache.
    logic [7:0]  arch    [logic [31:0]];
    logic [7:0]  backing [logic [31:0]];
    // Which line the cache should hold per index and whether it owes a write-back.
    logic        m_valid [4];
    logic        m_dirty [4];
    logic [25:0] m_tag   [4];
    logic [127:0] last_wb = '0;

    logic [31:0] ra, rv;
    logic [1:0]  rs;
    int          n;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_line(input logic [31:0] a, input bit from_backing);
        logic [127:0] l;
        logic [31:0]  k;
        l = '0;
        for (int b = 0; b < 16; b++) begin
            k = {a[31:4], 4'h0} + 32'(b);
            if (from_backing) begin
                if (backing.exists(k)) l[8*b +: 8] = backing[k];
            end else begin
                if (arch.exists(k)) l[8*b +: 8] = arch[k];
            end
        end
        return l;
    endfunction

    // Issue one store (caller sits at a negedge), play memory, check traffic and latency.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] val, input logic [1:0] size,
                            input int delay, input bit keep, input bit after_resp);
        logic [1:0]  idx;
        logic [25:0] tg;
        logic [31:0] victim, ph_addr, la;
        bit exp_hit, exp_wb, done, busy_ok, stable_ok;
        int exp_lat, cyc, pcnt, cur, ph, n_wb, n_fill;
        idx = addr[5:4];
        tg = addr[31:6];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb = !exp_hit && m_valid[idx] && m_dirty[idx];
        victim = {m_tag[idx], idx, 4'h0};
        exp_lat = (exp_hit ? 1 : (exp_wb ? 4 + 2 * delay : 3 + delay)) + (after_resp ? 1 : 0);
        cyc = 0; pcnt = 0; cur = 0; n_wb = 0; n_fill = 0;
        done = 0; busy_ok = 1; stable_ok = 1; ph_addr = '0;

        bus.cache_wenable = 1'b1;
        bus.cache_physical_address = addr;
        bus.cache_store_value = val;
        bus.cache_store_size = size;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.mem_ready = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.store_success === 1'b1) begin
                done = 1;
                if (bus.busy !== 1'b1) busy_ok = 0;
            end else if (bus.mem_req === 1'b1) begin
                if (bus.busy !== 1'b1) busy_ok = 0;
                ph = bus.mem_we ? 1 : 2;
                if (ph != cur) begin
                    cur = ph;
                    pcnt = 0;
                    ph_addr = bus.mem_addr;
                    if (ph == 1) begin
                        n_wb++;
                        last_wb = bus.mem_wdata;
                        check("wb_addr", bus.mem_addr, victim);
                        check("wb_data", bus.mem_wdata, model_line(victim, 0));
                    end else begin
                        n_fill++;
                        check("fill_addr", bus.mem_addr, {addr[31:4], 4'h0});
                    end
                end else begin
                    pcnt++;
                    if (bus.mem_addr !== ph_addr) stable_ok = 0;
                end
                if (pcnt == delay) begin
                    if (ph == 1) begin
                        bus.mem_ready = 1'b1;
                    end else begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata = model_line(addr, 1);
                    end
                end
            end
        end
        check("success_seen", done, 1'b1);
        check("latency", cyc, exp_lat);
        check("wb_count", n_wb, exp_wb);
        check("fill_count", n_fill, !exp_hit);
        check("busy_while_active", busy_ok, 1'b1);
        check("mem_addr_stable", stable_ok, 1'b1);

        if (exp_wb) begin
            for (int b = 0; b < 16; b++) begin
                la = victim + 32'(b);
                backing[la] = arch.exists(la) ? arch[la] : 8'h00;
            end
        end
        if (size == BYTE_SIZE) begin
            arch[addr] = val[7:0];
        end else begin
            for (int b = 0; b < 4; b++) begin
                la = {addr[31:2], 2'b00} + 32'(b);
                arch[la] = val[8*b +: 8];
            end
        end
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b1;
        m_tag[idx] = tg;

        if (!keep) begin
            bus.cache_wenable = 1'b0;
            @(negedge clk);
            check("no_second_pulse", bus.store_success, 1'b0);
            check("idle_after_resp", bus.busy, 1'b0);
        end
    endtask

    initial begin
        bus.cache_wenable = 1'b0;
        bus.cache_physical_address = '0;
        bus.cache_store_value = '0;
        bus.cache_store_size = BYTE_SIZE;
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_store_success", bus.store_success, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // Cold word store, fill answered two cycles after FILL entry.
        do_store(32'd4, 32'd26, FULL_WORD_SIZE, 2, 0, 0);
        // Word then byte store on the resident line.
        do_store(32'd8, 32'hFFFF_FFFF, FULL_WORD_SIZE, 0, 0, 0);
        do_store(32'd8, 32'h0000_0002, BYTE_SIZE, 0, 0, 0);
        // Conflicting address forces the dirty line 0 out.
        do_store(32'd64, 32'hCAFE_0040, FULL_WORD_SIZE, 1, 0, 0);
        check("evict_word1", last_wb[63:32], 32'd26);
        check("evict_word2", last_wb[95:64], 32'hFFFF_FF02);
        // Slow memory: request held and address stable for five waiting cycles.
        do_store(32'h90, 32'h1234_5678, FULL_WORD_SIZE, 5, 0, 0);

        // Reset while a fill is outstanding.
        bus.cache_wenable = 1'b1;
        bus.cache_physical_address = 32'hA0;
        bus.cache_store_value = 32'hDEAD_BEEF;
        bus.cache_store_size = FULL_WORD_SIZE;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("fill_before_rst", bus.mem_req, 1'b1);
        check("fill_before_rst_we", bus.mem_we, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.cache_wenable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_fill_mem_req", bus.mem_req, 1'b0);
        check("rst_fill_busy", bus.busy, 1'b0);
        check("rst_fill_success", bus.store_success, 1'b0);
        arch = backing;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        @(negedge clk);
        do_store(32'd4, 32'd77, FULL_WORD_SIZE, 0, 0, 0);

        // Back-to-back stores to one line with the request held throughout.
        do_store(32'd12, 32'hA5A5_0C0C, FULL_WORD_SIZE, 0, 1, 0);
        do_store(32'd13, 32'h0000_005A, BYTE_SIZE, 0, 0, 1);

        // Stray memory handshakes while idle must be ignored.
        bus.mem_ready = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = '1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("stray_mem_req", bus.mem_req, 1'b0);
        check("stray_busy", bus.busy, 1'b0);

        // Random stores over four tags per index so hits, clean and dirty misses all occur.
        for (int i = 0; i < 40; i++) begin
            ra = 32'($urandom_range(0, 255));
            rv = $urandom;
            rs = 2'($urandom_range(0, 3));
            do_store(ra, rv, rs, $urandom_range(0, 3), 0, 0);
        end

        // Evict every line so all cached contents are compared against the model.
        for (int i = 0; i < 4; i++) begin
            do_store({26'd100, 2'(i), 4'h0}, 32'h0, FULL_WORD_SIZE, 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
